// File: rtl/passive_security_alarm_pkg.sv
// Shared definitions for the passive security alarm and its dashboard decoder.
// Contents:
//   ALARM_STATE_W - width of the AlarmState status code
//   alarm_state_e - FSM state encoding as seen on AlarmState
package passive_security_alarm_pkg;

    localparam int ALARM_STATE_W = 2;

    typedef enum logic [ALARM_STATE_W-1:0] {
        ST_IDLE     = 2'b00,
        ST_ARMING   = 2'b01,
        ST_ALERT    = 2'b10,
        ST_SILENCED = 2'b11
    } alarm_state_e;

endpackage

// File: rtl/passive_debounce.sv
// Single-bit debounce filter. The filtered output follows raw only after raw
// has differed from it for CYCLES consecutive rising edges; any shorter
// excursion is discarded.
// Ports:
//   clk      - system clock
//   reset    - synchronous active-high reset (filtered and counter to 0)
//   raw      - unfiltered sensor level
//   filtered - debounced level
module passive_debounce #(
    parameter int CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic filtered
);

    localparam int CNT_W = $clog2(CYCLES) + 1;

    logic             filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (raw != filt_q) begin
            // The edge on which the counter already shows CYCLES-1 is the
            // CYCLES-th consecutive mismatch, so the change is accepted here.
            if (cnt_q == CNT_W'(CYCLES - 1)) begin
                filt_d = raw;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filtered = filt_q;

endmodule

// File: rtl/passive_security_alarm.sv
// Passive car security block: warns when the lights are on, a door is open
// and the ignition is off. Every sensor is debounced, the condition must hold
// for WARN_DELAY cycles before the chime sounds, and the driver may silence it.
// Ports:
//   clk, reset        - system clock, synchronous active-high reset
//   CarLightsOnSign   - raw lights-on sensor
//   OpenDoorSign      - raw door-open sensors, one bit per door
//   IgnitionSignalOn  - raw ignition sensor
//   AckButton         - silence request (level, not debounced)
//   PassiveSignal     - filtered alarm condition, registered
//   ChimeOut          - chime drive, square wave while in ALERT
//   DoorOpenMask      - debounced door states
//   AlarmState        - FSM state code (also the debug view of the FSM)
module passive_security_alarm
    import passive_security_alarm_pkg::*;
#(
    parameter int NUM_DOORS         = 4,
    parameter int DEBOUNCE_CYCLES   = 4,
    parameter int WARN_DELAY        = 8,
    parameter int CHIME_HALF_PERIOD = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     CarLightsOnSign,
    input  logic [NUM_DOORS-1:0]     OpenDoorSign,
    input  logic                     IgnitionSignalOn,
    input  logic                     AckButton,
    output logic                     PassiveSignal,
    output logic                     ChimeOut,
    output logic [NUM_DOORS-1:0]     DoorOpenMask,
    output logic [ALARM_STATE_W-1:0] AlarmState
);

    localparam int DLY_W   = $clog2(WARN_DELAY) + 1;
    localparam int CHIME_W = $clog2(CHIME_HALF_PERIOD) + 1;
    localparam int NUM_IN  = NUM_DOORS + 2;

    // Sensor vector layout: bit 0 lights, bit 1 ignition, bits above doors.
    logic [NUM_IN-1:0] raw_vec;
    logic [NUM_IN-1:0] filt_vec;

    assign raw_vec = {OpenDoorSign, IgnitionSignalOn, CarLightsOnSign};

    for (genvar i = 0; i < NUM_IN; i++) begin : gen_deb
        passive_debounce #(
            .CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clk      (clk),
            .reset    (reset),
            .raw      (raw_vec[i]),
            .filtered (filt_vec[i])
        );
    end

    logic                 lights_f;
    logic                 ign_f;
    logic [NUM_DOORS-1:0] door_f;
    logic                 cond;

    assign lights_f = filt_vec[0];
    assign ign_f    = filt_vec[1];
    assign door_f   = filt_vec[NUM_IN-1:2];
    assign cond     = lights_f & (|door_f) & ~ign_f;

    alarm_state_e       state_q, state_d;
    logic [DLY_W-1:0]   dly_q, dly_d;
    logic [CHIME_W-1:0] chime_cnt_q, chime_cnt_d;
    logic               passive_q, passive_d;

    always_comb begin
        state_d     = state_q;
        dly_d       = dly_q;
        // Chime phase only advances while staying in ALERT; any other path
        // leaves it cleared so the next ALERT entry starts high.
        chime_cnt_d = '0;
        passive_d   = cond;
        case (state_q)
            ST_IDLE: begin
                if (cond) begin
                    state_d = ST_ARMING;
                    dly_d   = '0;
                end
            end
            ST_ARMING: begin
                if (!cond) begin
                    state_d = ST_IDLE;
                    dly_d   = '0;
                end else if (dly_q == DLY_W'(WARN_DELAY - 1)) begin
                    state_d = ST_ALERT;
                    dly_d   = '0;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            ST_ALERT: begin
                // Loss of the condition takes priority over a silence request.
                if (!cond) begin
                    state_d = ST_IDLE;
                end else if (AckButton) begin
                    state_d = ST_SILENCED;
                end else if (chime_cnt_q != CHIME_W'(2 * CHIME_HALF_PERIOD - 1)) begin
                    chime_cnt_d = chime_cnt_q + 1'b1;
                end
            end
            ST_SILENCED: begin
                // Only a fall of cond re-arms; extra doors opening do not.
                if (!cond) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            dly_q       <= '0;
            chime_cnt_q <= '0;
            passive_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dly_q       <= dly_d;
            chime_cnt_q <= chime_cnt_d;
            passive_q   <= passive_d;
        end
    end

    // First half of each chime period is high.
    assign ChimeOut      = (state_q == ST_ALERT) &&
                           (chime_cnt_q < CHIME_W'(CHIME_HALF_PERIOD));
    assign PassiveSignal = passive_q;
    assign DoorOpenMask  = door_f;
    assign AlarmState    = state_q;

endmodule
